// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a WORD_CHUNKS*DATA_BITS word as back-to-back UART
// frames, lowest-order chunk first. Each frame is a start bit, data LSB first,
// an optional parity bit, then STOP_BITS stop bits. Each bit lasts BAUD_DIV clocks.
//
// Optional feature macro: UART_PARITY_EN. When it is defined, a parity bit
// follows the data bits. The parity bit is the XOR of the chunk data, inverted
// when PARITY_ODD=1.
//
// Handshake: send_i is sampled on every rising edge. It is accepted only when
// the FSM is in IDLE, which includes the done_o cycle. While busy_o is high,
// send_i is ignored. Acceptance latches word_i. The start bit appears on tx_o
// in the very next cycle.
//
// state_dbg exposes the current FSM state encoding for observation.
module uart_word_tx #(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_BITS   = 8,
  parameter int WORD_CHUNKS = 4,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_BITS*WORD_CHUNKS-1:0] word_i,
  input  logic                             send_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             tx_o,
  output logic [2:0]                       state_dbg
);

  localparam int WW = DATA_BITS * WORD_CHUNKS;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(DATA_BITS);
  localparam int CW = (WORD_CHUNKS > 1) ? $clog2(WORD_CHUNKS) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] DATA_LAST  = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST  = NW'(STOP_BITS - 1);
  localparam logic [CW-1:0] CHUNK_LAST = CW'(WORD_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud_cnt, baud_n;
  logic [NW-1:0]   bit_cnt, bit_n;
  logic [CW-1:0]   chunk_cnt, chunk_n;
  logic [WW-1:0]   shreg, shreg_n;
  logic            tx_n, busy_n, done_n;
  logic            baud_last;

`ifdef UART_PARITY_EN
  localparam logic PAR_INV = (PARITY_ODD != 0);
  logic par_acc, par_n;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign state_dbg = state;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      chunk_cnt <= '0;
      shreg     <= '0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
`ifdef UART_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      chunk_cnt <= chunk_n;
      shreg     <= shreg_n;
      tx_o      <= tx_n;
      busy_o    <= busy_n;
      done_o    <= done_n;
`ifdef UART_PARITY_EN
      par_acc   <= par_n;
`endif
    end
  end

  // Next-state sequencing. Outputs are derived from the next state, so the
  // registered tx_o lines up exactly with the state it belongs to.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    chunk_n = chunk_cnt;
    shreg_n = shreg;
    done_n  = 1'b0;
`ifdef UART_PARITY_EN
    par_n   = par_acc;
`endif

    unique case (state)
      S_IDLE: begin
        if (send_i) begin
          state_n = S_START;
          shreg_n = word_i;
          baud_n  = '0;
          bit_n   = '0;
          chunk_n = '0;
`ifdef UART_PARITY_EN
          par_n   = 1'b0;
`endif
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_n  = '0;
          // Shifting right after each bit leaves the next chunk's LSB at bit 0.
          shreg_n = shreg >> 1;
`ifdef UART_PARITY_EN
          par_n   = par_acc ^ shreg[0];
`endif
          if (bit_cnt == DATA_LAST) begin
            bit_n = '0;
`ifdef UART_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_cnt + NW'(1);
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
`endif

      S_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n = '0;
            if (chunk_cnt == CHUNK_LAST) begin
              chunk_n = '0;
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              chunk_n = chunk_cnt + CW'(1);
              state_n = S_START;
`ifdef UART_PARITY_EN
              par_n   = 1'b0;
`endif
            end
          end else begin
            bit_n = bit_cnt + NW'(1);
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Line level and busy flag for the upcoming cycle.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != S_IDLE);
    unique case (state_n)
      S_IDLE:   tx_n = 1'b1;
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_n = par_n ^ PAR_INV;
`endif
      S_STOP:   tx_n = 1'b1;
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter BAUD_DIV, default 434, SHALL set clock cycles per serial bit period (legal 2..65535).
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per serial frame (legal 5..8).
REQ-003 Parameter WORD_CHUNKS, default 4, SHALL set frames per word (legal 1..8).
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop bits per frame (legal 1 or 2).
REQ-005 Parameter PARITY_ODD, default 0, SHALL select odd (1) or even (0) parity; used only when UART_PARITY_EN is defined.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-008 word_i  input  DATA_BITS*WORD_CHUNKS  SHALL carry the word to transmit.
REQ-009 send_i  input  1  SHALL request transmission of word_i.
REQ-010 busy_o  output  1  SHALL be high while a word is in transmission.
REQ-011 done_o  output  1  SHALL pulse high for one cycle when a word completes.
REQ-012 tx_o  output  1  SHALL be the serial line, idle high.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a bit counter, a baud counter (0..BAUD_DIV-1) and a chunk counter (0..WORD_CHUNKS-1) SHALL sequence it.
REQ-014 In IDLE, send_i=1 SHALL latch word_i into a shift register, set busy_o=1 and enter START on the next edge; send_i while busy_o=1 SHALL be ignored.
REQ-015 START SHALL drive tx_o=0 for exactly BAUD_DIV cycles, starting the cycle after acceptance.
REQ-016 DATA SHALL drive DATA_BITS bits LSB first, each held exactly BAUD_DIV cycles.
REQ-017 Chunks SHALL be sent lowest-order first: chunk k = word bits [k*DATA_BITS +: DATA_BITS].
REQ-018 PARITY (present only per REQ-028) SHALL drive one parity bit for BAUD_DIV cycles.
REQ-019 STOP SHALL drive tx_o=1 for STOP_BITS*BAUD_DIV cycles.
REQ-020 After STOP, if chunks remain the FSM SHALL enter START of the next chunk with no idle gap; otherwise it SHALL enter IDLE.
REQ-021 On the cycle the FSM re-enters IDLE after the last chunk, done_o SHALL be 1 and busy_o SHALL be 0; send_i in that cycle SHALL be accepted normally.
REQ-022 Frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*BAUD_DIV cycles, P=1 with parity else 0; word length WORD_CHUNKS times that.
REQ-023 tx_o SHALL be registered (glitch-free); busy_o and done_o SHALL be registered.
REQ-024 Counter widths SHALL be $clog2-sized from parameters; counters SHALL wrap to 0 at terminal count, never overflow.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, tx_o=1, busy_o=0, done_o=0, and clear all counters and the shift register.
REQ-026 Reset mid-frame SHALL abort the word with no done_o pulse; after release the block SHALL wait for a new send_i.
REQ-027 First acceptance SHALL be possible in the first rising edge after rst deasserts.

Configuration
REQ-028 With macro UART_PARITY_EN defined, PARITY state SHALL exist and carry XOR of chunk data bits (inverted if PARITY_ODD=1); without it, PARITY state and logic SHALL be absent and DATA SHALL go directly to STOP.

Verification
(All: BAUD_DIV=4, DATA_BITS=8, WORD_CHUNKS=2, STOP_BITS=1, PARITY_ODD=0.)
REQ-029 No parity, word_i=0xA55A, send_i pulse -> tx_o: frame 0x5A then 0xA5, LSB first, 40 cycles each; done_o pulses at cycle 81 after acceptance; busy_o high cycles 1..80.
REQ-030 UART_PARITY_EN, word_i=0x0301 -> chunk 0x01 parity bit 1, chunk 0x03 parity bit 0; 44 cycles per frame, done_o at cycle 89.
REQ-031 send_i held high continuously with word_i=0x00FF -> back-to-back words; second START begins the cycle after done_o, tx_o never idles between words.
REQ-032 send_i pulse with word_i=0x1234 during busy -> ignored; transmitted data unchanged, single done_o.
REQ-033 rst asserted at cycle 20 of first frame -> tx_o=1, busy_o=0 same cycle, no done_o; new send_i after release transmits full word correctly.
REQ-034 STOP_BITS=2, no parity -> stop high 8 cycles, frame 44 cycles, done_o at cycle 89.
